id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
- Parametrised decode stage for the Buceros core: decodes one RV32I/RV64I instruction per cycle.
- Forwards operands from N write-back channels and resolves branches and jumps in ID.
- Detects load-use hazards and stalls.
- Registers all decoded fields into an ID/EX pipeline register with valid/ready handshakes on both sides.
- Sits between the IF/ID register and the EX stage.

Parameters:
- XLEN, 32, datapath and immediate width (32 or 64).
- ADDR_W, 32, instruction address width.
- FWD_PORTS, 2, number of forwarding channels (>=1); index 0 has highest priority (youngest stage).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- if_valid_i  in  1  instruction on inst_i/pc_i valid.
- id_ready_o  out  1  ID accepts the instruction this cycle.
- pc_i  in  ADDR_W  instruction PC.
- inst_i  in  32  instruction word.
- rs1_data_i  in  XLEN  regfile read port 1 (async read).
- rs2_data_i  in  XLEN  regfile read port 2.
- rs1_addr_o  out  5  regfile read address 1 (combinational).
- rs2_addr_o  out  5  regfile read address 2 (combinational).
- fwd_en_i  in  FWD_PORTS  per-channel write enable.
- fwd_addr_i  in  5*FWD_PORTS  per-channel destination register.
- fwd_data_i  in  XLEN*FWD_PORTS  per-channel result.
- ex_rmem_i  in  1  instruction currently in EX is a load.
- ex_rd_i  in  5  destination register of the EX instruction.
- flush_i  in  1  kill the instruction in the ID/EX register (trap/redirect from later stage).
- redirect_o  out  1  taken branch/jump accepted this cycle (combinational).
- redirect_pc_o  out  ADDR_W  target PC (combinational).
- id_valid_o  out  1  ID/EX register holds a valid instruction.
- ex_ready_i  in  1  EX accepts the ID/EX contents.
- Registered fields: pc_o ADDR_W, opcode_o 7, funct3_o 3, funct7_o 7, imm_o XLEN, rd_o 5, wreg_en_o 1, rmem_en_o 1, wmem_en_o 1, rs1_data_o XLEN, rs2_data_o XLEN, illegal_o 1.

Behaviour:
- Reset: id_valid_o=0; every registered field=0. Reset overrides flush and handshake.
- Operand select:
  - x0 always reads 0 and is never forwarded.
  - Otherwise the lowest-index channel with fwd_en & addr match supplies the value; with no match, the regfile value is used.
- Load-use stall (stall) when all of: if_valid_i & ex_rmem_i & ex_rd_i!=0, and ex_rd_i equals rs1 (used by types R/I/S/B/JALR) or rs2 (used by types R/S/B).
- Handshake: id_ready_o = ~stall & (~id_valid_o | ex_ready_i). Accept = if_valid_i & id_ready_o.
- Register update, in priority order each cycle:
  - rst: clear.
  - flush_i: id_valid_o<=0.
  - Accept: load all fields, id_valid_o<=1. Latency is 1 cycle.
  - Otherwise, if ex_ready_i: id_valid_o<=0 (a bubble is inserted during stall).
  - Otherwise: hold all fields.
- Simultaneous flush_i & accept: flush wins and the incoming instruction is dropped. IF must also redirect.
- Branch resolution (combinational from the forwarded operands):
  - BEQ/BNE/BLT/BGE/BLTU/BGEU use full XLEN compares; JAL and JALR are always taken.
  - redirect_o = accept & taken. It is never asserted while stalled or not ready.
  - Target: B/JAL = pc_i+imm; JALR = (rs1+imm) with bit0 forced 0. Arithmetic is modulo 2^ADDR_W.
- Immediates are sign-extended to XLEN. U-type is placed in bits [31:12], low 12 bits zero, sign-extended for XLEN=64.
- wreg_en=0 when rd=0.
- illegal_o=1 for:
  - an unknown opcode[6:2];
  - opcode[1:0]!=11;
  - OP funct7 not in {0000000, 0100000} (subject to the optional feature below).
- An illegal instruction has wreg_en/rmem/wmem forced 0 and is still passed with valid.
- Wrap-around: forwarding with all channels enabled to the same register uses channel 0.

Optional Feature:
- Macro BUCEROS_RV_M_EN.
- Defined: OP/OP-32 with funct7=0000001 decodes legal (MUL/DIV family), wreg_en=1.
- Undefined: such instructions set illegal_o=1; no extra logic is generated.

Decomposition:
- buceros_header gains:
  - opcode[6:2] constants (OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC);
  - imm-type encoding;
  - funct3 branch codes.
- One sub-module: id_imm_gen (inst[31:0] and imm type -> XLEN immediate; purely combinational).

Test Plan:
- ADDI x1,x0,5 (0x00500093), ex_ready_i=1 -> next cycle id_valid_o=1, imm_o=5, rd_o=1, wreg_en_o=1, illegal_o=0.
- ADD x3,x1,x2 with fwd0=(x1,7), fwd1=(x1,9), regfile x2=4 -> rs1_data_o=7, rs2_data_o=4. Same instruction with fwd to x0 -> rs1_data_o=0.
- ex_rmem_i=1, ex_rd_i=1, inst ADD x3,x1,x2 -> id_ready_o=0 for 1 cycle, id_valid_o=0 (bubble); then accepted after ex_rmem_i drops.
- BLT x1,x2,+16 at pc 0x100, x1=-1, x2=1 -> redirect_o=1, redirect_pc_o=0x110. Same with BLTU -> redirect_o=0.
- JALR x0,x1,3 with x1=0x200 -> redirect_pc_o=0x202. ex_ready_i=0 with id_valid_o=1 -> id_ready_o=0, redirect_o=0, fields held.
- flush_i together with accept -> id_valid_o=0 next cycle. MUL inst 0x02208033 -> illegal_o=1 without BUCEROS_RV_M_EN, 0 with it.

Source files
------------

// File: rtl/id_stage_pipe_pkg.sv
// ============================================================================
// Module  : id_stage_pipe_pkg
// Brief   : Shared decode constants for the Buceros ID stage: opcode[6:2]
//           codes, immediate-type encoding, branch funct3 codes and the OP
//           funct7 legality check.
//           Optional macro BUCEROS_RV_M_EN: accept the MUL/DIV funct7 code.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package id_stage_pipe_pkg;

  // Major opcode field inst[6:2] (inst[1:0] must be 2'b11 for 32-bit encodings)
  localparam logic [4:0] OPC_LOAD      = 5'b00000;
  localparam logic [4:0] OPC_STORE     = 5'b01000;
  localparam logic [4:0] OPC_BRANCH    = 5'b11000;
  localparam logic [4:0] OPC_JAL       = 5'b11011;
  localparam logic [4:0] OPC_JALR      = 5'b11001;
  localparam logic [4:0] OPC_OP        = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
  localparam logic [4:0] OPC_LUI       = 5'b01101;
  localparam logic [4:0] OPC_AUIPC     = 5'b00101;
  // Word-sized forms, only meaningful on RV64
  localparam logic [4:0] OPC_OP_32     = 5'b01110;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;

  // Immediate format selected by the decoder
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  // Branch condition codes (funct3 of BRANCH)
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // OP / OP-32 funct7 codes
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
`ifdef BUCEROS_RV_M_EN
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
`endif

  // Register-register ops only accept a small set of funct7 values
  function automatic logic op_funct7_legal(input logic [6:0] f7);
`ifdef BUCEROS_RV_M_EN
    return (f7 == F7_BASE) || (f7 == F7_ALT) || (f7 == F7_MULDIV);
`else
    return (f7 == F7_BASE) || (f7 == F7_ALT);
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_imm_gen.sv
// ============================================================================
// Module  : id_imm_gen
// Brief   : Purely combinational immediate generator. Assembles the 32-bit
//           RISC-V immediate for the selected format and sign-extends it to
//           XLEN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module id_imm_gen
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  input  imm_type_e       imm_type_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;
  logic        unused_opcode;

  // The opcode bits never contribute to an immediate
  assign unused_opcode = ^inst_i[6:0];

  // Scatter/gather of the immediate bits for each encoding format
  always_comb begin
    imm32 = '0;
    case (imm_type_i)
      IMM_I:   imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S:   imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B:   imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                        inst_i[30:25], inst_i[11:8], 1'b0};
      IMM_U:   imm32 = {inst_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                        inst_i[20], inst_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  if (XLEN > 32) begin : g_imm_sext
    assign imm_o = {{(XLEN-32){imm32[31]}}, imm32};
  end else begin : g_imm_direct
    assign imm_o = imm32;
  end

endmodule

`default_nettype wire

// File: rtl/id_stage_pipe.sv
// ============================================================================
// Module  : id_stage_pipe
// Brief   : Buceros decode stage. Decodes one RV32I/RV64I instruction per
//           cycle, forwards operands from FWD_PORTS write-back channels,
//           resolves branches/jumps, stalls on load-use hazards and registers
//           the decoded fields into the ID/EX register (valid/ready on both
//           sides).
//           Optional macro BUCEROS_RV_M_EN: OP/OP-32 funct7=0000001 is legal.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 32,
  parameter int FWD_PORTS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  // IF/ID side
  input  logic                      if_valid_i,
  output logic                      id_ready_o,
  input  logic [ADDR_W-1:0]         pc_i,
  input  logic [31:0]               inst_i,
  // Register file
  input  logic [XLEN-1:0]           rs1_data_i,
  input  logic [XLEN-1:0]           rs2_data_i,
  output logic [4:0]                rs1_addr_o,
  output logic [4:0]                rs2_addr_o,
  // Forwarding channels (index 0 = youngest, highest priority)
  input  logic [FWD_PORTS-1:0]      fwd_en_i,
  input  logic [5*FWD_PORTS-1:0]    fwd_addr_i,
  input  logic [XLEN*FWD_PORTS-1:0] fwd_data_i,
  // Hazard / control from later stages
  input  logic                      ex_rmem_i,
  input  logic [4:0]                ex_rd_i,
  input  logic                      flush_i,
  output logic                      redirect_o,
  output logic [ADDR_W-1:0]         redirect_pc_o,
  // ID/EX register
  output logic                      id_valid_o,
  input  logic                      ex_ready_i,
  output logic [ADDR_W-1:0]         pc_o,
  output logic [6:0]                opcode_o,
  output logic [2:0]                funct3_o,
  output logic [6:0]                funct7_o,
  output logic [XLEN-1:0]           imm_o,
  output logic [4:0]                rd_o,
  output logic                      wreg_en_o,
  output logic                      rmem_en_o,
  output logic                      wmem_en_o,
  output logic [XLEN-1:0]           rs1_data_o,
  output logic [XLEN-1:0]           rs2_data_o,
  output logic                      illegal_o
);

  // --------------------------------------------------------------------------
  // Field extraction
  // --------------------------------------------------------------------------
  logic [4:0] w_rs1_addr;
  logic [4:0] w_rs2_addr;
  logic [4:0] w_rd;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;

  assign w_rs1_addr = inst_i[19:15];
  assign w_rs2_addr = inst_i[24:20];
  assign w_rd       = inst_i[11:7];
  assign w_funct3   = inst_i[14:12];
  assign w_funct7   = inst_i[31:25];

  assign rs1_addr_o = w_rs1_addr;
  assign rs2_addr_o = w_rs2_addr;

  // --------------------------------------------------------------------------
  // Opcode decode
  // --------------------------------------------------------------------------
  imm_type_e w_imm_type;
  logic      w_known;
  logic      w_f7_bad;
  logic      w_use_rs1;
  logic      w_use_rs2;
  logic      w_writes_rd;
  logic      w_is_load;
  logic      w_is_store;
  logic      w_is_branch;
  logic      w_is_jal;
  logic      w_is_jalr;

  // Classify the instruction; anything not 32-bit encoded counts as unknown
  always_comb begin
    w_imm_type  = IMM_NONE;
    w_known     = 1'b0;
    w_f7_bad    = 1'b0;
    w_use_rs1   = 1'b0;
    w_use_rs2   = 1'b0;
    w_writes_rd = 1'b0;
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_branch = 1'b0;
    w_is_jal    = 1'b0;
    w_is_jalr   = 1'b0;
    if (inst_i[1:0] == 2'b11) begin
      case (inst_i[6:2])
        OPC_LOAD: begin
          w_known = 1'b1; w_imm_type = IMM_I; w_use_rs1 = 1'b1;
          w_writes_rd = 1'b1; w_is_load = 1'b1;
        end
        OPC_STORE: begin
          w_known = 1'b1; w_imm_type = IMM_S; w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1; w_is_store = 1'b1;
        end
        OPC_BRANCH: begin
          w_known = 1'b1; w_imm_type = IMM_B; w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1; w_is_branch = 1'b1;
        end
        OPC_JAL: begin
          w_known = 1'b1; w_imm_type = IMM_J; w_writes_rd = 1'b1;
          w_is_jal = 1'b1;
        end
        OPC_JALR: begin
          w_known = 1'b1; w_imm_type = IMM_I; w_use_rs1 = 1'b1;
          w_writes_rd = 1'b1; w_is_jalr = 1'b1;
        end
        OPC_OP: begin
          w_known = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
          w_writes_rd = 1'b1; w_f7_bad = ~op_funct7_legal(w_funct7);
        end
        OPC_OP_IMM: begin
          w_known = 1'b1; w_imm_type = IMM_I; w_use_rs1 = 1'b1;
          w_writes_rd = 1'b1;
        end
        OPC_LUI, OPC_AUIPC: begin
          w_known = 1'b1; w_imm_type = IMM_U; w_writes_rd = 1'b1;
        end
        OPC_OP_32: begin
          if (XLEN == 64) begin
            w_known = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            w_writes_rd = 1'b1; w_f7_bad = ~op_funct7_legal(w_funct7);
          end
        end
        OPC_OP_IMM_32: begin
          if (XLEN == 64) begin
            w_known = 1'b1; w_imm_type = IMM_I; w_use_rs1 = 1'b1;
            w_writes_rd = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  logic            illegal_d;
  logic            wreg_d;
  logic            rmem_d;
  logic            wmem_d;
  logic [XLEN-1:0] imm_d;

  // Illegal instructions travel down the pipe but must not change state
  assign illegal_d = ~w_known | w_f7_bad;
  assign wreg_d    = w_writes_rd & (w_rd != 5'd0) & ~illegal_d;
  assign rmem_d    = w_is_load & ~illegal_d;
  assign wmem_d    = w_is_store & ~illegal_d;

  id_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .inst_i     (inst_i),
    .imm_type_i (w_imm_type),
    .imm_o      (imm_d)
  );

  // --------------------------------------------------------------------------
  // Operand forwarding
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] rs1_d;
  logic [XLEN-1:0] rs2_d;

  // Walk channels oldest-to-youngest so channel 0 overrides the rest; x0 is hardwired
  always_comb begin
    rs1_d = rs1_data_i;
    rs2_d = rs2_data_i;
    for (int i = FWD_PORTS - 1; i >= 0; i--) begin
      if (fwd_en_i[i] && (fwd_addr_i[i*5 +: 5] == w_rs1_addr))
        rs1_d = fwd_data_i[i*XLEN +: XLEN];
      if (fwd_en_i[i] && (fwd_addr_i[i*5 +: 5] == w_rs2_addr))
        rs2_d = fwd_data_i[i*XLEN +: XLEN];
    end
    if (w_rs1_addr == 5'd0) rs1_d = '0;
    if (w_rs2_addr == 5'd0) rs2_d = '0;
  end

  // --------------------------------------------------------------------------
  // Hazard detection and handshake
  // --------------------------------------------------------------------------
  logic valid_q;
  logic w_stall;
  logic w_accept;

  assign w_stall  = if_valid_i & ex_rmem_i & (ex_rd_i != 5'd0) &
                    ((w_use_rs1 & (ex_rd_i == w_rs1_addr)) |
                     (w_use_rs2 & (ex_rd_i == w_rs2_addr)));
  assign id_ready_o = ~w_stall & (~valid_q | ex_ready_i);
  assign w_accept   = if_valid_i & id_ready_o;

  // --------------------------------------------------------------------------
  // Branch / jump resolution
  // --------------------------------------------------------------------------
  logic w_cond;
  logic w_taken;

  // Full-width compare on the forwarded operands
  always_comb begin
    w_cond = 1'b0;
    case (w_funct3)
      F3_BEQ:  w_cond = (rs1_d == rs2_d);
      F3_BNE:  w_cond = (rs1_d != rs2_d);
      F3_BLT:  w_cond = ($signed(rs1_d) <  $signed(rs2_d));
      F3_BGE:  w_cond = ($signed(rs1_d) >= $signed(rs2_d));
      F3_BLTU: w_cond = (rs1_d <  rs2_d);
      F3_BGEU: w_cond = (rs1_d >= rs2_d);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken = (w_is_branch & w_cond) | w_is_jal | w_is_jalr;

  logic [ADDR_W-1:0] w_imm_a;
  logic [ADDR_W-1:0] w_rs1_a;
  logic [ADDR_W-1:0] w_jalr_sum;

  // Bring immediate and base register to address width (wraps modulo 2^ADDR_W)
  if (ADDR_W <= XLEN) begin : g_addr_trunc
    assign w_imm_a = imm_d[ADDR_W-1:0];
    assign w_rs1_a = rs1_d[ADDR_W-1:0];
  end else begin : g_addr_ext
    assign w_imm_a = {{(ADDR_W-XLEN){imm_d[XLEN-1]}}, imm_d};
    assign w_rs1_a = {{(ADDR_W-XLEN){1'b0}}, rs1_d};
  end

  assign w_jalr_sum    = w_rs1_a + w_imm_a;
  assign redirect_pc_o = w_is_jalr ? {w_jalr_sum[ADDR_W-1:1], 1'b0}
                                   : (pc_i + w_imm_a);
  assign redirect_o    = w_accept & w_taken;

  // --------------------------------------------------------------------------
  // ID/EX register
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] pc_q;
  logic [6:0]        opcode_q;
  logic [2:0]        funct3_q;
  logic [6:0]        funct7_q;
  logic [XLEN-1:0]   imm_q;
  logic [4:0]        rd_q;
  logic              wreg_q;
  logic              rmem_q;
  logic              wmem_q;
  logic [XLEN-1:0]   rs1_q;
  logic [XLEN-1:0]   rs2_q;
  logic              illegal_q;

  // Priority: reset, flush, accept, drain to a bubble, hold
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      opcode_q  <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      wreg_q    <= 1'b0;
      rmem_q    <= 1'b0;
      wmem_q    <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      illegal_q <= 1'b0;
    end else if (flush_i) begin
      valid_q   <= 1'b0;
    end else if (w_accept) begin
      valid_q   <= 1'b1;
      pc_q      <= pc_i;
      opcode_q  <= inst_i[6:0];
      funct3_q  <= w_funct3;
      funct7_q  <= w_funct7;
      imm_q     <= imm_d;
      rd_q      <= w_rd;
      wreg_q    <= wreg_d;
      rmem_q    <= rmem_d;
      wmem_q    <= wmem_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      illegal_q <= illegal_d;
    end else if (ex_ready_i) begin
      valid_q   <= 1'b0;
    end
  end

  assign id_valid_o = valid_q;
  assign pc_o       = pc_q;
  assign opcode_o   = opcode_q;
  assign funct3_o   = funct3_q;
  assign funct7_o   = funct7_q;
  assign imm_o      = imm_q;
  assign rd_o       = rd_q;
  assign wreg_en_o  = wreg_q;
  assign rmem_en_o  = rmem_q;
  assign wmem_en_o  = wmem_q;
  assign rs1_data_o = rs1_q;
  assign rs2_data_o = rs2_q;
  assign illegal_o  = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
// ============================================================================
// Module  : tb_id_stage_pipe
// Brief   : Self-checking bench for id_stage_pipe (XLEN=32, ADDR_W=32,
//           FWD_PORTS=2): directed scenarios plus a randomized run against an
//           instruction-level reference model of the ID stage.
//           Honors BUCEROS_RV_M_EN for the MUL/DIV expectations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_i;
  logic        id_ready_o;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [1:0]  fwd_en_i;
  logic [9:0]  fwd_addr_i;
  logic [63:0] fwd_data_i;
  logic        ex_rmem_i;
  logic [4:0]  ex_rd_i;
  logic        flush_i;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        id_valid_o;
  logic        ex_ready_i;
  logic [31:0] pc_o;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [31:0] imm_o;
  logic [4:0]  rd_o;
  logic        wreg_en_o;
  logic        rmem_en_o;
  logic        wmem_en_o;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic        illegal_o;

  id_stage_pipe #(.XLEN(32), .ADDR_W(32), .FWD_PORTS(2)) dut (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid_i), .id_ready_o(id_ready_o),
    .pc_i(pc_i), .inst_i(inst_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .fwd_en_i(fwd_en_i), .fwd_addr_i(fwd_addr_i), .fwd_data_i(fwd_data_i),
    .ex_rmem_i(ex_rmem_i), .ex_rd_i(ex_rd_i), .flush_i(flush_i),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .id_valid_o(id_valid_o), .ex_ready_i(ex_ready_i),
    .pc_o(pc_o), .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
    .imm_o(imm_o), .rd_o(rd_o), .wreg_en_o(wreg_en_o), .rmem_en_o(rmem_en_o),
    .wmem_en_o(wmem_en_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wreg;
    logic        rmem;
    logic        wmem;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        illegal;
  } fields_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] regs [32];
  logic [1:0]  fen;
  logic [4:0]  fadr [2];
  logic [31:0] fdat [2];
  fields_t     exp_f;
  logic        exp_valid;

  function automatic fields_t dut_fields();
    return {pc_o, opcode_o, funct3_o, funct7_o, imm_o, rd_o, wreg_en_o,
            rmem_en_o, wmem_en_o, rs1_data_o, rs2_data_o, illegal_o};
  endfunction

  // Value an instruction should see for register r: x0, youngest matching channel, regfile
  function automatic logic [31:0] model_operand(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    for (int i = 0; i < 2; i++)
      if (fen[i] && fadr[i] == r) return fdat[i];
    return regs[r];
  endfunction

  // Instruction-level reference: what the ISA says this instruction does in ID
  function automatic void model(input logic [31:0] inst, input logic [31:0] pc,
                                input logic [31:0] a, input logic [31:0] b,
                                output fields_t f, output bit u1, output bit u2,
                                output bit tk, output logic [31:0] tgt);
    int s;
    bit m_ok;
    bit wr;
    s = inst;
`ifdef BUCEROS_RV_M_EN
    m_ok = 1;
`else
    m_ok = 0;
`endif
    f = '0;
    f.pc = pc; f.opcode = inst[6:0]; f.funct3 = inst[14:12]; f.funct7 = inst[31:25];
    f.rd = inst[11:7]; f.rs1 = a; f.rs2 = b;
    u1 = 0; u2 = 0; tk = 0; wr = 0; tgt = 0;
    case (inst[6:0])
      7'h03: begin f.imm = s >>> 20; u1 = 1; wr = 1; f.rmem = 1; end
      7'h23: begin f.imm = ((s >>> 25) <<< 5) | int'(inst[11:7]); u1 = 1; u2 = 1; f.wmem = 1; end
      7'h63: begin
        f.imm = ((s >>> 31) <<< 12) | (int'(inst[7]) << 11) |
                (int'(inst[30:25]) << 5) | (int'(inst[11:8]) << 1);
        u1 = 1; u2 = 1;
        case (inst[14:12])
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = (int'(a) < int'(b));
          3'd5: tk = (int'(a) >= int'(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: tk = 0;
        endcase
        tgt = pc + f.imm;
      end
      7'h6F: begin
        f.imm = ((s >>> 31) <<< 20) | (int'(inst[19:12]) << 12) |
                (int'(inst[20]) << 11) | (int'(inst[30:21]) << 1);
        wr = 1; tk = 1; tgt = pc + f.imm;
      end
      7'h67: begin f.imm = s >>> 20; u1 = 1; wr = 1; tk = 1; tgt = (a + f.imm) & ~32'd1; end
      7'h33: begin
        u1 = 1; u2 = 1; wr = 1;
        f.illegal = !(inst[31:25] == 7'h00 || inst[31:25] == 7'h20 ||
                      (m_ok && inst[31:25] == 7'h01));
      end
      7'h13: begin f.imm = s >>> 20; u1 = 1; wr = 1; end
      7'h37, 7'h17: begin f.imm = s & 32'hFFFFF000; wr = 1; end
      default: f.illegal = 1;
    endcase
    f.wreg = wr && inst[11:7] != 0 && !f.illegal;
  endfunction

  // Apply one cycle of inputs; regfile returns the addressed entries
  task automatic set_inputs(input logic [31:0] inst, input logic [31:0] pc,
                            input logic v, input logic rmem, input logic [4:0] exrd,
                            input logic flush, input logic rdy);
    if_valid_i = v; inst_i = inst; pc_i = pc;
    rs1_data_i = regs[inst[19:15]]; rs2_data_i = regs[inst[24:20]];
    fwd_en_i = fen; fwd_addr_i = {fadr[1], fadr[0]}; fwd_data_i = {fdat[1], fdat[0]};
    ex_rmem_i = rmem; ex_rd_i = exrd; flush_i = flush; ex_ready_i = rdy;
  endtask

  task automatic test_reset();
    fields_t g;
    fen = 2'b00; fadr[0] = 0; fadr[1] = 0; fdat[0] = 0; fdat[1] = 0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    rst = 1'b1;
    set_inputs(32'h00500093, 32'h40, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", id_valid_o); end
    g = dut_fields();
    checks++;
    if (g !== '0) begin errors++; $display("FAIL reset_fields: got %h exp 0", g); end
    @(negedge clk);
    rst = 1'b0;
    set_inputs(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if (id_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", id_ready_o); end
  endtask

  task automatic test_addi();
    @(negedge clk);
    set_inputs(32'h00500093, 32'h80, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    checks++;
    if ({id_valid_o, imm_o, rd_o, wreg_en_o, illegal_o} !== {1'b1, 32'd5, 5'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL addi: got v=%b imm=%h rd=%0d we=%b ill=%b exp v=1 imm=5 rd=1 we=1 ill=0",
               id_valid_o, imm_o, rd_o, wreg_en_o, illegal_o);
    end
  endtask

  task automatic test_forward();
    regs[1] = 32'h55; regs[2] = 32'h4; regs[0] = 32'h99;
    fen = 2'b11; fadr[0] = 5'd1; fdat[0] = 32'd7; fadr[1] = 5'd1; fdat[1] = 32'd9;
    @(negedge clk);
    set_inputs(32'h002081B3, 32'h84, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if ({rs1_addr_o, rs2_addr_o} !== {5'd1, 5'd2}) begin
      errors++; $display("FAIL rs_addr: got %0d,%0d exp 1,2", rs1_addr_o, rs2_addr_o);
    end
    @(posedge clk); #1;
    checks++;
    if ({rs1_data_o, rs2_data_o} !== {32'd7, 32'd4}) begin
      errors++; $display("FAIL fwd_prio: got %h,%h exp 7,4", rs1_data_o, rs2_data_o);
    end
    fadr[0] = 5'd0; fadr[1] = 5'd0;
    @(negedge clk);
    set_inputs(32'h002001B3, 32'h88, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (rs1_data_o !== 32'd0) begin errors++; $display("FAIL fwd_x0: got %h exp 0", rs1_data_o); end
    fen = 2'b10; fadr[0] = 5'd2; fadr[1] = 5'd2; fdat[1] = 32'h33;
    @(negedge clk);
    set_inputs(32'h002081B3, 32'h8C, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    checks++;
    if ({rs1_data_o, rs2_data_o} !== {32'h55, 32'h33}) begin
      errors++; $display("FAIL fwd_ch1: got %h,%h exp 55,33", rs1_data_o, rs2_data_o);
    end
    fen = 2'b00;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    set_inputs(32'h002081B3, 32'h90, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1);
    #1;
    checks++;
    if ({id_ready_o, redirect_o} !== 2'b00) begin
      errors++; $display("FAIL lu_rs1_ready: got rdy=%b redir=%b exp 0,0", id_ready_o, redirect_o);
    end
    @(posedge clk); #1;
    checks++;
    if (id_valid_o !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %b exp 0", id_valid_o); end
    @(negedge clk);
    set_inputs(32'h002081B3, 32'h90, 1'b1, 1'b1, 5'd2, 1'b0, 1'b1);
    #1;
    checks++;
    if (id_ready_o !== 1'b0) begin errors++; $display("FAIL lu_rs2_ready: got %b exp 0", id_ready_o); end
    @(negedge clk);
    set_inputs(32'h002081B3, 32'h90, 1'b1, 1'b0, 5'd1, 1'b0, 1'b1);
    #1;
    checks++;
    if (id_ready_o !== 1'b1) begin errors++; $display("FAIL lu_release: got %b exp 1", id_ready_o); end
    @(posedge clk); #1;
    checks++;
    if ({id_valid_o, rd_o} !== {1'b1, 5'd3}) begin
      errors++; $display("FAIL lu_accept: got v=%b rd=%0d exp 1,3", id_valid_o, rd_o);
    end
    @(negedge clk);
    set_inputs(32'h000081B7, 32'h94, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1);
    #1;
    checks++;
    if (id_ready_o !== 1'b1) begin errors++; $display("FAIL lu_lui_nostall: got %b exp 1", id_ready_o); end
  endtask

  task automatic test_branch();
    regs[1] = 32'hFFFF_FFFF; regs[2] = 32'd1;
    @(negedge clk);
    set_inputs(32'h0020C863, 32'h100, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h110}) begin
      errors++; $display("FAIL blt: got redir=%b pc=%h exp 1,110", redirect_o, redirect_pc_o);
    end
    @(negedge clk);
    set_inputs(32'h0020E863, 32'h100, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if (redirect_o !== 1'b0) begin errors++; $display("FAIL bltu: got %b exp 0", redirect_o); end
  endtask

  task automatic test_jalr_hold();
    regs[1] = 32'h200;
    @(negedge clk);
    set_inputs(32'h00308067, 32'h180, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h202}) begin
      errors++; $display("FAIL jalr: got redir=%b pc=%h exp 1,202", redirect_o, redirect_pc_o);
    end
    @(negedge clk);
    set_inputs(32'h00000063, 32'h300, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if ({id_ready_o, redirect_o} !== 2'b00) begin
      errors++; $display("FAIL hold_ready: got rdy=%b redir=%b exp 0,0", id_ready_o, redirect_o);
    end
    @(posedge clk); #1;
    checks++;
    if ({id_valid_o, pc_o, opcode_o, imm_o} !== {1'b1, 32'h180, 7'h67, 32'd3}) begin
      errors++;
      $display("FAIL hold_fields: got v=%b pc=%h op=%h imm=%h exp 1,180,67,3", id_valid_o, pc_o, opcode_o, imm_o);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    set_inputs(32'h00500093, 32'h400, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    #1;
    checks++;
    if (id_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b exp 1", id_ready_o); end
    @(posedge clk); #1;
    checks++;
    if (id_valid_o !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b exp 0", id_valid_o); end
  endtask

  task automatic test_illegal();
    logic [31:0] insts [4];
    logic [1:0]  exp_iw [4];
    insts[0] = 32'h02208033; insts[1] = 32'h022082B3;
    insts[2] = 32'h00500090; insts[3] = 32'h0000018B;
`ifdef BUCEROS_RV_M_EN
    exp_iw[0] = 2'b00; exp_iw[1] = 2'b01;
`else
    exp_iw[0] = 2'b10; exp_iw[1] = 2'b10;
`endif
    exp_iw[2] = 2'b10; exp_iw[3] = 2'b10;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_inputs(insts[k], 32'h500, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
      @(posedge clk); #1;
      checks++;
      if ({id_valid_o, illegal_o, wreg_en_o} !== {1'b1, exp_iw[k]}) begin
        errors++;
        $display("FAIL illegal_%0d: got v=%b ill=%b we=%b exp v=1 ill/we=%b", k, id_valid_o, illegal_o, wreg_en_o, exp_iw[k]);
      end
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  ops [10];
    ops = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h33, 7'h13, 7'h37, 7'h17, 7'h00};
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 9)];
    if (w[6:0] == 7'h00) w[6:0] = 7'($urandom);
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    w[11:7]  = 5'($urandom_range(0, 3));
    if (w[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  task automatic test_random();
    logic [31:0] inst, pc, a, b, tgt;
    logic        v, rdy, flush, rmem;
    logic [4:0]  exrd;
    fields_t     f, g;
    bit          u1, u2, tk, stall, ready, acc;
    @(negedge clk);
    rst = 1'b1;
    set_inputs(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    @(posedge clk);
    exp_valid = 1'b0; exp_f = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (n != 0) @(negedge clk);
      inst = rand_inst(); pc = $urandom;
      v = ($urandom_range(0, 3) != 0); rdy = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0); rmem = ($urandom_range(0, 2) == 0);
      exrd = 5'($urandom_range(0, 3));
      fen = 2'($urandom);
      for (int i = 0; i < 2; i++) begin fadr[i] = 5'($urandom_range(0, 3)); fdat[i] = $urandom; end
      for (int i = 0; i < 4; i++) regs[i] = $urandom;
      set_inputs(inst, pc, v, rmem, exrd, flush, rdy);
      a = model_operand(inst[19:15]); b = model_operand(inst[24:20]);
      model(inst, pc, a, b, f, u1, u2, tk, tgt);
      stall = v && rmem && exrd != 0 &&
              ((u1 && exrd == inst[19:15]) || (u2 && exrd == inst[24:20]));
      ready = !stall && (!exp_valid || rdy);
      acc = v && ready;
      #1;
      checks++;
      if ({id_ready_o, redirect_o} !== {ready, acc && tk}) begin
        errors++;
        $display("FAIL rnd_hs[%0d]: got rdy=%b redir=%b exp %b,%b inst=%h", n, id_ready_o, redirect_o, ready, acc && tk, inst);
      end
      if (acc && tk) begin
        checks++;
        if (redirect_pc_o !== tgt) begin
          errors++; $display("FAIL rnd_target[%0d]: got %h exp %h inst=%h", n, redirect_pc_o, tgt, inst);
        end
      end
      @(posedge clk);
      if (flush) exp_valid = 1'b0;
      else if (acc) begin exp_valid = 1'b1; exp_f = f; end
      else if (rdy) exp_valid = 1'b0;
      #1;
      g = dut_fields();
      checks++;
      if (id_valid_o !== exp_valid) begin
        errors++; $display("FAIL rnd_valid[%0d]: got %b exp %b", n, id_valid_o, exp_valid);
      end
      checks++;
      if (g !== exp_f) begin
        errors++; $display("FAIL rnd_fields[%0d]: got %h exp %h", n, g, exp_f);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_forward();
    test_load_use();
    test_branch();
    test_jalr_hold();
    test_flush();
    test_illegal();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
